// File: rtl/pkt_rcv_pkg.sv
// Shared definitions for the SPI-slave packet receiver (pkt_rcv):
// FSM state encodings and the default packet width. The packet sender
// imports the same package so the address/content layout matches at both ends.
package pkt_rcv_pkg;

    // Default packet width: upper half is the address, lower half the content.
    localparam int PKT_W_DEF = 16;

    // Receiver frame FSM.
    typedef enum logic [1:0] {
        ST_IDL = 2'd0,  // waiting for a load falling edge
        ST_SHF = 2'd1,  // shifting bits on sclk rising edges
        ST_CHK = 2'd2   // one cycle: validate bit count, publish or flag error
    } state_t;

endpackage : pkt_rcv_pkg

// File: rtl/pkt_rcv_sync_edge.sv
// Multi-flop input synchronizer with edge detection.
// Brings one asynchronous pin into the clk domain and flags its rising and
// falling edges by comparing the synchronized level with one extra
// registered copy. i_rst_val sets the level the pin reads as during reset.
module pkt_rcv_sync_edge #(
    parameter int STAGES = 2   // synchronizer depth, at least 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    input  logic i_rst_val,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Synchronizer chain plus one delayed copy for edge detection.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{i_rst_val}};
            r_prev <= i_rst_val;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  =  r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] &  r_prev;

endmodule : pkt_rcv_sync_edge

// File: rtl/pkt_rcv.sv
// pkt_rcv: SPI-slave packet receiver.
// sclk/load/sdi are synchronized into the clk domain; data shifts in
// MSB-first on sclk rising edges while load is low. When load rises the bit
// count is checked: exactly PKT_W bits publishes pkt/addr/cont with a
// one-cycle pvld pulse, anything else gives a one-cycle perr pulse.
// Optional daisy-chain output enabled by macro PKT_RCV_CHAIN_EN; without it
// sdo is tied low.
module pkt_rcv
    import pkt_rcv_pkg::*;
#(
    parameter int PKT_W       = PKT_W_DEF,  // packet width, even
    parameter int SYNC_STAGES = 2           // input synchronizer depth, >= 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sclk,
    input  logic               load,
    input  logic               sdi,
    output logic [PKT_W-1:0]   pkt,
    output logic [PKT_W/2-1:0] addr,
    output logic [PKT_W/2-1:0] cont,
    output logic               pvld,
    output logic               perr,
    output logic               busy,
    output logic               sdo
);

    // Count saturates one past a full packet so over-long frames stay
    // distinguishable from good ones without wrapping.
    localparam int             CNT_W    = $clog2(PKT_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PKT_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(PKT_W + 1);

    // Synchronized inputs and edges.
    logic w_sclk_rise, w_sclk_lvl, w_sclk_fall;
    logic w_load_rise, w_load_fall, w_load_lvl;
    logic w_sdi_lvl, w_sdi_rise, w_sdi_fall;

    // FSM and datapath controls.
    state_t           r_state, w_state_nxt;
    logic             w_clr, w_shift, w_good, w_bad;
    logic [PKT_W-1:0] r_shreg;
    logic [CNT_W-1:0] r_cnt;
    logic [PKT_W-1:0] r_pkt;
    logic             r_pvld, r_perr;

    // Edge outputs nothing downstream needs.
    logic w_unused_edges;
    assign w_unused_edges = &{w_sclk_lvl, w_sclk_fall, w_load_lvl, w_sdi_rise, w_sdi_fall};

    // sclk idles low, load idles high (no frame) out of reset.
    pkt_rcv_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_async  (sclk),
        .i_rst_val(1'b0),
        .o_level  (w_sclk_lvl),
        .o_rise   (w_sclk_rise),
        .o_fall   (w_sclk_fall)
    );

    pkt_rcv_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_load (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_async  (load),
        .i_rst_val(1'b1),
        .o_level  (w_load_lvl),
        .o_rise   (w_load_rise),
        .o_fall   (w_load_fall)
    );

    // Same depth as sclk, so the sdi level lines up with the detected sclk edge.
    pkt_rcv_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_async  (sdi),
        .i_rst_val(1'b0),
        .o_level  (w_sdi_lvl),
        .o_rise   (w_sdi_rise),
        .o_fall   (w_sdi_fall)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDL;
        else        r_state <= w_state_nxt;
    end

    // Next-state and datapath control decode.
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_shift     = 1'b0;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        case (r_state)
            ST_IDL: begin
                // sclk activity with load high is ignored here.
                if (w_load_fall) begin
                    w_clr       = 1'b1;
                    w_state_nxt = ST_SHF;
                end
            end
            ST_SHF: begin
                // A coincident sclk edge is shifted before the frame closes.
                w_shift = w_sclk_rise;
                if (w_load_rise) w_state_nxt = ST_CHK;
            end
            ST_CHK: begin
                if (r_cnt == CNT_FULL) w_good = 1'b1;
                else                   w_bad  = 1'b1;
                w_state_nxt = ST_IDL;
            end
            default: w_state_nxt = ST_IDL;
        endcase
    end

    // Shift register, bit counter, published packet and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_pkt   <= '0;
            r_pvld  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_pvld <= w_good;
            r_perr <= w_bad;
            if (w_clr) begin
                r_cnt <= '0;
`ifndef PKT_RCV_CHAIN_EN
                r_shreg <= '0;
`endif
                // In chain mode the previous packet is kept so it can stream
                // out on sdo during the next frame; the count check alone
                // guarantees a good frame fully replaces it.
            end else if (w_shift) begin
                r_shreg <= {r_shreg[PKT_W-2:0], w_sdi_lvl};
                if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
            end
            if (w_good) r_pkt <= r_shreg;
        end
    end

`ifdef PKT_RCV_CHAIN_EN
    logic r_sdo;

    // Daisy-chain output: the bit about to leave the shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_sdo <= 1'b0;
        else if (w_shift) r_sdo <= r_shreg[PKT_W-1];
    end

    assign sdo = r_sdo;
`else
    assign sdo = 1'b0;
`endif

    assign pkt  = r_pkt;
    assign addr = r_pkt[PKT_W-1:PKT_W/2];
    assign cont = r_pkt[PKT_W/2-1:0];
    assign pvld = r_pvld;
    assign perr = r_perr;
    assign busy = (r_state == ST_SHF);

endmodule : pkt_rcv
